// File: rtl/dilithium_pkg.sv
// Shared Dilithium sizing constants and small types used by the t0 packing path.
// Every t0 packer/unpacker in the slice takes its dimensions from here.
package dilithium_pkg;

    localparam int N                  = 256;
    localparam int D                  = 13;
    localparam int POLYT0_PACKEDBYTES = 416;
    localparam int T0_HALF            = 4096;
    localparam int T0_MIN             = -4095;

    typedef logic [D-1:0] t0_word_t;

endpackage

// File: rtl/polyt0_pack_conv.sv
// Combinational map of one signed t0 coefficient to its 13-bit packed form t = 4096 - coeff,
// plus a flag for coefficients outside -4095..4096.
import dilithium_pkg::*;

module polyt0_pack_conv (
    input  logic [31:0]  i_coeff,
    output t0_word_t     o_t,
    output logic         o_illegal
);

    // Only the low D bits of the 32-bit difference survive, so a D-bit subtraction is exact.
    assign o_t       = t0_word_t'(T0_HALF) - i_coeff[D-1:0];
    assign o_illegal = ($signed(i_coeff) > T0_HALF) || ($signed(i_coeff) < T0_MIN);

endmodule

// File: rtl/polyt0_pack_stream.sv
// Streaming t0 packer: one coefficient in per handshake, one packed byte out per handshake,
// using a 28-bit bit accumulator so the 3328-bit packed polynomial never exists in parallel.
import dilithium_pkg::*;

module polyt0_pack_stream (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_coeff,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        done,
    output logic        range_err
);

    logic [27:0] r_acc;
    logic [4:0]  r_nbits;
    logic [7:0]  r_coef_cnt;
    logic [8:0]  r_byte_cnt;
    logic        r_done;
    logic        r_range_err;

    t0_word_t    w_t;
    logic        w_illegal;
    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_last_byte;
    logic [4:0]  w_ins_pos;
    logic [27:0] w_ins;
    logic [27:0] w_acc_base;
    logic [4:0]  w_nbits_next;

    polyt0_pack_conv u_conv (
        .i_coeff   (in_coeff),
        .o_t       (w_t),
        .o_illegal (w_illegal)
    );

    // Handshake readiness depends on registered fill level only, never on the other side's strobe.
    assign in_ready    = (r_nbits < 5'd16);
    assign out_valid   = (r_nbits >= 5'd8);
    assign w_in_fire   = in_valid && in_ready;
    assign w_out_fire  = out_valid && out_ready;
    assign w_last_byte = (r_byte_cnt == 9'(POLYT0_PACKEDBYTES - 1));

    assign out_data    = r_acc[7:0];
    assign out_last    = out_valid && w_last_byte;
    assign done        = r_done;
    assign range_err   = r_range_err;

    // When a byte leaves on the same edge, the new coefficient lands 8 bits lower.
    assign w_ins_pos    = w_out_fire ? (r_nbits - 5'd8) : r_nbits;
    assign w_ins        = {15'd0, w_t} << w_ins_pos;
    assign w_acc_base   = w_out_fire ? {8'd0, r_acc[27:8]} : r_acc;
    assign w_nbits_next = r_nbits + (w_in_fire ? 5'd13 : 5'd0) - (w_out_fire ? 5'd8 : 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_nbits     <= '0;
            r_coef_cnt  <= '0;
            r_byte_cnt  <= '0;
            r_done      <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            r_acc   <= w_acc_base | (w_in_fire ? w_ins : 28'd0);
            r_nbits <= w_nbits_next;
            r_done  <= w_out_fire && w_last_byte;
            if (w_in_fire) begin
                r_coef_cnt <= (r_coef_cnt == 8'(N - 1)) ? 8'd0 : r_coef_cnt + 8'd1;
                if (w_illegal) begin
                    r_range_err <= 1'b1;
                end
            end
            if (w_out_fire) begin
                r_byte_cnt <= w_last_byte ? 9'd0 : r_byte_cnt + 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_polyt0_pack_stream.sv
// Self-checking bench for polyt0_pack_stream: a bit-queue reference model is compared every cycle,
// and literal byte values plus an unpack round trip pin the model to the packing rules.
module tb_polyt0_pack_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_coeff;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        done;
    logic        range_err;

    int checks = 0;
    int passes = 0;
    int cycle  = 0;

    int          stim[$];
    logic [7:0]  capBytes[$];
    int          capCycle[$];
    int          lastIdx[$];
    int          doneCount;

    bit          modelBits[$];
    int          byteIdx;
    bit          expDone;
    bit          expErr;

    polyt0_pack_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coeff  (in_coeff),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Reference model: the packed string is a plain FIFO of bits, 13 pushed per coefficient
    // LSB first, 8 popped per byte. Fill-level rules come straight from the queue length.
    always @(negedge clk) begin
        logic [7:0]  eb;
        logic [12:0] t;
        bit          inFire;
        bit          outFire;
        int          c;
        cycle++;
        if (rst) begin
            modelBits.delete();
            byteIdx = 0;
            expDone = 1'b0;
            expErr  = 1'b0;
        end else begin
            checkOutput("in_ready", int'(in_ready), int'(modelBits.size() < 16));
            checkOutput("out_valid", int'(out_valid), int'(modelBits.size() >= 8));
            checkOutput("done", int'(done), int'(expDone));
            checkOutput("range_err", int'(range_err), int'(expErr));
            if (out_valid && modelBits.size() >= 8) begin
                for (int i = 0; i < 8; i++) eb[i] = modelBits[i];
                checkOutput("out_data", int'(out_data), int'(eb));
                checkOutput("out_last", int'(out_last), int'(byteIdx == 415));
            end
            inFire  = in_valid && in_ready;
            outFire = out_valid && out_ready;
            expDone = outFire && (byteIdx == 415);
            if (done) doneCount++;
            if (outFire) begin
                capBytes.push_back(out_data);
                capCycle.push_back(cycle);
                if (out_last) lastIdx.push_back(capBytes.size() - 1);
                for (int i = 0; i < 8; i++) begin
                    if (modelBits.size() > 0) void'(modelBits.pop_front());
                end
                byteIdx = (byteIdx == 415) ? 0 : byteIdx + 1;
            end
            if (inFire) begin
                c = int'(in_coeff);
                t = 13'(4096 - c);
                for (int i = 0; i < 13; i++) modelBits.push_back(t[i]);
                if (c > 4096 || c < -4095) expErr = 1'b1;
            end
        end
    end

    task automatic clearCapture();
        capBytes.delete();
        capCycle.delete();
        lastIdx.delete();
        doneCount = 0;
    endtask

    task automatic applyStimulus(input int n, input int vPct, input int rPct, input bit drain);
        int idx;
        int budget;
        bit fire;
        idx    = 0;
        budget = 0;
        while (idx < n && budget < 20000) begin
            in_valid  = ($urandom_range(99) < vPct);
            in_coeff  = stim[idx];
            out_ready = ($urandom_range(99) < rPct);
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (fire) idx++;
            budget++;
        end
        in_valid = 1'b0;
        if (idx < n) checkOutput("feed_timeout", idx, n);
        if (drain) begin
            budget = 0;
            while ((modelBits.size() != 0 || out_valid) && budget < 5000) begin
                out_ready = ($urandom_range(99) < rPct) || (rPct == 0);
                @(posedge clk);
                #1;
                budget++;
            end
            checkOutput("drain_timeout", modelBits.size(), 0);
            @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic resetChecks();
        checkOutput("rst_in_ready", int'(in_ready), 1);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_data", int'(out_data), 0);
        checkOutput("rst_out_last", int'(out_last), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_range_err", int'(range_err), 0);
    endtask

    // Independent t0 unpack of the captured bytes back into coefficients.
    task automatic verifyUnpack(input int byteOff, input int coefOff);
        logic [7:0]  by;
        logic [12:0] t;
        int          pos;
        if (capBytes.size() < byteOff + 416) begin
            checkOutput("unpack_len", capBytes.size(), byteOff + 416);
            return;
        end
        for (int k = 0; k < 256; k++) begin
            t = '0;
            for (int b = 0; b < 13; b++) begin
                pos  = 13 * k + b;
                by   = capBytes[byteOff + pos / 8];
                t[b] = by[pos % 8];
            end
            checkOutput("unpack_coeff", 4096 - int'(t), stim[coefOff + k]);
        end
    endtask

    task automatic fillStim(input int n, input int mode);
        stim.delete();
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       stim.push_back(0);
                1:       stim.push_back(4096);
                2:       stim.push_back(-4095);
                default: stim.push_back(int'($urandom_range(8191)) - 4095);
            endcase
        end
    endtask

    initial begin
        int bad;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_coeff  = '0;
        out_ready = 1'b0;
        doneCount = 0;
        repeat (2) @(posedge clk);
        #1;
        resetChecks();
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] all-zero polynomial");
        clearCapture();
        fillStim(256, 0);
        applyStimulus(256, 100, 100, 1'b1);
        checkOutput("zero_len", capBytes.size(), 416);
        if (capBytes.size() == 416) begin
            checkOutput("zero_b0", int'(capBytes[0]), 8'h00);
            checkOutput("zero_b1", int'(capBytes[1]), 8'h10);
            checkOutput("zero_b2", int'(capBytes[2]), 8'h00);
            checkOutput("zero_b3", int'(capBytes[3]), 8'h02);
            checkOutput("zero_b4", int'(capBytes[4]), 8'h40);
            checkOutput("zero_b14", int'(capBytes[14]), 8'h10);
            checkOutput("zero_b415", int'(capBytes[415]), 8'h80);
        end
        checkOutput("zero_last_count", lastIdx.size(), 1);
        if (lastIdx.size() > 0) checkOutput("zero_last_idx", lastIdx[0], 415);
        checkOutput("zero_done_count", doneCount, 1);

        $display("[TB] all-4096 and all-minus-4095 polynomials");
        clearCapture();
        fillStim(256, 1);
        applyStimulus(256, 100, 100, 1'b1);
        bad = 0;
        foreach (capBytes[i]) if (capBytes[i] != 8'h00) bad++;
        checkOutput("max_len", capBytes.size(), 416);
        checkOutput("max_nonzero_bytes", bad, 0);
        checkOutput("max_range_err", int'(range_err), 0);
        clearCapture();
        fillStim(256, 2);
        applyStimulus(256, 100, 100, 1'b1);
        bad = 0;
        foreach (capBytes[i]) if (capBytes[i] != 8'hFF) bad++;
        checkOutput("min_len", capBytes.size(), 416);
        checkOutput("min_non_ff_bytes", bad, 0);
        checkOutput("min_range_err", int'(range_err), 0);

        $display("[TB] random legal polynomial, random handshakes");
        clearCapture();
        fillStim(256, 3);
        applyStimulus(256, 60, 55, 1'b1);
        verifyUnpack(0, 0);
        checkOutput("rand_done_count", doneCount, 1);

        $display("[TB] illegal coefficient at index 5");
        clearCapture();
        fillStim(256, 0);
        stim[5] = 4097;
        applyStimulus(256, 100, 100, 1'b1);
        checkOutput("ill_range_err", int'(range_err), 1);
        checkOutput("ill_len", capBytes.size(), 416);
        if (capBytes.size() == 416) begin
            checkOutput("ill_b8", int'(capBytes[8]), 8'hFF);
            checkOutput("ill_b9", int'(capBytes[9]), 8'h3F);
        end

        $display("[TB] reset after 100 coefficients");
        clearCapture();
        fillStim(256, 3);
        applyStimulus(100, 100, 50, 1'b0);
        rst = 1'b1;
        #2;
        resetChecks();
        @(posedge clk);
        #1;
        resetChecks();
        rst = 1'b0;
        clearCapture();
        fillStim(256, 3);
        applyStimulus(256, 80, 70, 1'b1);
        verifyUnpack(0, 0);
        checkOutput("post_rst_last_count", lastIdx.size(), 1);

        $display("[TB] two polynomials back-to-back at full rate");
        clearCapture();
        fillStim(512, 3);
        applyStimulus(512, 100, 100, 1'b1);
        checkOutput("b2b_len", capBytes.size(), 832);
        if (capCycle.size() == 832) checkOutput("b2b_span", capCycle[831] - capCycle[0], 831);
        checkOutput("b2b_last_count", lastIdx.size(), 2);
        if (lastIdx.size() == 2) begin
            checkOutput("b2b_last0", lastIdx[0], 415);
            checkOutput("b2b_last1", lastIdx[1], 831);
        end
        checkOutput("b2b_done_count", doneCount, 2);
        verifyUnpack(0, 0);
        verifyUnpack(416, 256);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/polyt0_pack_stream.md
# polyt0_pack_stream

Streaming packer for Dilithium t0 polynomials, the transmit-side counterpart of the t0 unpacker. It accepts 256 signed coefficients one per handshake, maps each to t = 4096 − coeff (13 bits), and emits the 416-byte packed string one byte per handshake. It sits between the Power2Round stage and the secret-key serializer, so sk bytes are produced without a 3328-bit parallel bus.

## Interface
- Parameters: none. All sizes come from the shared package.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  coefficient valid.
- in_ready  out  1  coefficient accepted when in_valid && in_ready.
- in_coeff  in  32  signed coefficient; legal range −4095..4096.
- out_valid  out  1  packed byte valid.
- out_ready  in  1  byte consumed when out_valid && out_ready.
- out_data  out  8  packed byte.
- out_last  out  1  high with byte 415 of each polynomial.
- done  out  1  one-cycle pulse on the cycle after the byte-415 handshake.
- range_err  out  1  sticky; set when an out-of-range coefficient is accepted.

## Operation
- Bit layout: coefficient k occupies string bits 13k..13k+12, LSB first. Byte j is string bits 8j..8j+7, little-endian.
- Accumulator: acc (28 bits) and nbits (0..28); valid bits are acc[nbits−1:0].
- Accept rule: in_ready = (nbits < 16). On accept, t[12:0] is written at acc bit position nbits, or at nbits−8 when a byte handshake occurs in the same cycle, and nbits increases by 13.
- Emit rule: out_valid = (nbits ≥ 8) and out_data = acc[7:0]. On the byte handshake, acc shifts right by 8 and nbits decreases by 8.
- Simultaneous accept and emit: net nbits change is +5; both actions use the same edge.
- No explicit FSM. State is {acc, nbits, coef_cnt[7:0], byte_cnt[8:0]}.
  - coef_cnt wraps 255→0.
  - byte_cnt counts 0..415, then returns to 0 after the last byte.
  - nbits is exactly 0 at every polynomial boundary (3328 is divisible by 8).
- Back-to-back polynomials stream with no gap. Coefficient 0 of the next polynomial may be accepted while the previous polynomial's bytes drain.
- Range check: a coefficient is illegal when coeff > 4096 or coeff < −4095. Illegal coefficients still pack the low 13 bits of (4096 − coeff) and set range_err. range_err clears only on rst.
- Arithmetic: 32-bit signed subtraction, truncated to 13 bits.

## Timing
- Reset values:
  - in_ready = 1
  - out_valid = 0, out_data = 0x00
  - out_last = 0, done = 0
  - range_err = 0
  - acc, nbits, coef_cnt, byte_cnt = 0
- Reset mid-polynomial discards all partial state. The next accepted coefficient is coefficient 0 of a fresh polynomial.
- in_ready and out_valid are functions of registered nbits only. There is no combinational path from out_ready to in_ready or from in_valid to out_valid.
- Latency: a coefficient accepted on edge k makes its first byte visible from edge k+1 at the earliest.
- Throughput: one byte per cycle sustained with out_ready held high, i.e. 416 cycles per polynomial.
- out_data and out_last hold stable while out_valid && !out_ready.
- done asserts for exactly one cycle, the cycle after the byte-415 handshake.

## Structure
- Shared package dilithium_pkg holds:
  - N = 256
  - D = 13
  - POLYT0_PACKEDBYTES = 416
  - T0_HALF = 4096
  - T0_MIN = −4095
- Sub-module polyt0_pack_conv: combinational mapping coeff → t[12:0] plus the illegal flag. Reusable by a parallel packer.
- Top level holds the accumulator, counters and handshake logic.

## Test plan
- All 256 coefficients = 0 (t = 0x1000), out_ready = 1 → first bytes 00 10 00 02 40; output repeats the 13-byte pattern of t0..t7; 416 bytes total; out_last only on byte 415; done pulses once.
- All coefficients = 4096 → all 416 bytes 0x00. All coefficients = −4095 → all bytes 0xFF. range_err stays 0 in both cases.
- Random legal coefficients with random in_valid and out_ready → byte stream identical to the C reference pack_t0. in_ready never high while nbits ≥ 16. Feeding the bytes through the t0 unpacker returns the original coefficients.
- Coefficient 4097 at index 5 → range_err rises the next cycle and stays high; packed t = 0x1FFF at index 5; stream length unchanged.
- rst asserted after 100 coefficients → all outputs at reset values during reset; next full polynomial packs correctly from byte 0.
- Two polynomials back-to-back at full rate → 832 bytes in 832 consecutive cycles after fill; out_last on bytes 415 and 831; two done pulses.
